// File: rtl/ann_layer_sequencer_if.sv
// rtl/ann_layer_sequencer_if.sv - loader/datapath handshake bundle for the ANN layer sequencer
//
// Purpose: groups the loader handshake and the MAC datapath controls driven by
// the layer sequencer.
// Ports (by modport):
//   master (sequencer): in  image_weights_loaded
//                       out request_coef, coef_select, mac_clear, mac_en,
//                           input_addr, node_sel, layer_idx, node_latch,
//                           done_processing, busy
//   slave  (loader/datapath side): the same signals with directions reversed
interface ann_layer_sequencer_if #(
  parameter int NUM_INPUTS = 64,
  parameter int NUM_NODES  = 16,
  parameter int NUM_LAYERS = 4
);
  logic                          image_weights_loaded;
  logic                          request_coef;
  logic                          coef_select;
  logic                          mac_clear;
  logic                          mac_en;
  logic [$clog2(NUM_INPUTS)-1:0] input_addr;
  logic [$clog2(NUM_NODES)-1:0]  node_sel;
  logic [$clog2(NUM_LAYERS)-1:0] layer_idx;
  logic                          node_latch;
  logic                          done_processing;
  logic                          busy;

  modport master (
    input  image_weights_loaded,
    output request_coef, coef_select, mac_clear, mac_en, input_addr,
           node_sel, layer_idx, node_latch, done_processing, busy
  );

  modport slave (
    output image_weights_loaded,
    input  request_coef, coef_select, mac_clear, mac_en, input_addr,
           node_sel, layer_idx, node_latch, done_processing, busy
  );
endinterface

// File: rtl/ann_layer_sequencer.sv
// rtl/ann_layer_sequencer.sv - control FSM stepping the ANN MAC datapath through nodes and layers
//
// Purpose: for every layer, for every node: clear the accumulator, accumulate
// NUM_INPUTS products, latch the node result. Between layers it requests the
// next coefficient bank and waits for the loader; after the last layer it
// pulses done_processing.
// Ports:
//   clk  - system clock, rising-edge state updates
//   rst  - asynchronous active-high reset
//   bus  - ann_layer_sequencer_if.master (loader handshake + datapath controls)
module ann_layer_sequencer #(
  parameter int NUM_INPUTS = 64,
  parameter int NUM_NODES  = 16,
  parameter int NUM_LAYERS = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  ann_layer_sequencer_if.master  bus
);

  localparam int IW = $clog2(NUM_INPUTS);
  localparam int NW = $clog2(NUM_NODES);
  localparam int LW = $clog2(NUM_LAYERS);

  localparam logic [IW-1:0] LAST_INPUT = IW'(NUM_INPUTS - 1);
  localparam logic [NW-1:0] LAST_NODE  = NW'(NUM_NODES - 1);
  localparam logic [LW-1:0] LAST_LAYER = LW'(NUM_LAYERS - 1);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_CLEAR = 3'd1;
  localparam logic [2:0] ST_ACCUM = 3'd2;
  localparam logic [2:0] ST_LATCH = 3'd3;
  localparam logic [2:0] ST_REQ   = 3'd4;
  localparam logic [2:0] ST_DONE  = 3'd5;

  logic [2:0]    state;
  logic [IW-1:0] input_addr_q;
  logic [NW-1:0] node_q;
  logic [LW-1:0] layer_q;
  logic          coef_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_IDLE;
      input_addr_q <= '0;
      node_q       <= '0;
      layer_q      <= '0;
      coef_q       <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.image_weights_loaded) begin
            state        <= ST_CLEAR;
            input_addr_q <= '0;
            node_q       <= '0;
            layer_q      <= '0;
            coef_q       <= 1'b0;
          end
        end
        ST_CLEAR: begin
          input_addr_q <= '0;
          state        <= ST_ACCUM;
        end
        ST_ACCUM: begin
          // Hold on the last index rather than wrapping so the datapath never
          // sees an out-of-range address in the transition cycle.
          if (input_addr_q == LAST_INPUT) begin
            state <= ST_LATCH;
          end else begin
            input_addr_q <= input_addr_q + 1'b1;
          end
        end
        ST_LATCH: begin
          input_addr_q <= '0;
          if (node_q != LAST_NODE) begin
            node_q <= node_q + 1'b1;
            state  <= ST_CLEAR;
          end else if (layer_q == LAST_LAYER) begin
            state <= ST_DONE;
          end else begin
            state <= ST_REQ;
          end
        end
        ST_REQ: begin
          // The bank flips on each accepted handshake, so the loader always
          // fills the bank not currently feeding the datapath.
          if (bus.image_weights_loaded) begin
            coef_q  <= ~coef_q;
            layer_q <= layer_q + 1'b1;
            node_q  <= '0;
            state   <= ST_CLEAR;
          end
        end
        ST_DONE: begin
          input_addr_q <= '0;
          node_q       <= '0;
          layer_q      <= '0;
          coef_q       <= 1'b0;
          state        <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Every output is a decode of registered state, so the loader input has no
  // combinational path to any output.
  assign bus.busy            = (state != ST_IDLE);
  assign bus.mac_clear       = (state == ST_CLEAR);
  assign bus.mac_en          = (state == ST_ACCUM);
  assign bus.node_latch      = (state == ST_LATCH);
  assign bus.request_coef    = (state == ST_REQ);
  assign bus.done_processing = (state == ST_DONE);
  assign bus.input_addr      = input_addr_q;
  assign bus.node_sel        = node_q;
  assign bus.layer_idx       = layer_q;
  assign bus.coef_select     = coef_q;

endmodule

// File: tb/tb_ann_layer_sequencer.sv
// tb/tb_ann_layer_sequencer.sv - self-checking bench for ann_layer_sequencer
//
// Purpose: drives whole-image runs with randomized loader timing and stray
// loader pulses, and compares every cycle against a schedule computed from
// cycle offsets within each layer.
// Ports: none (top-level bench).
module tb_ann_layer_sequencer;

  localparam int NI        = 64;
  localparam int NN        = 16;
  localparam int NL        = 4;
  localparam int NODE_CYC  = 1 + NI + 1;
  localparam int LAYER_CYC = NN * NODE_CYC;

  typedef struct packed {
    logic       busy;
    logic       request_coef;
    logic       coef_select;
    logic       mac_clear;
    logic       mac_en;
    logic       node_latch;
    logic       done;
    logic [5:0] addr;
    logic [3:0] node;
    logic [1:0] layer;
  } obs_t;

  logic tb_clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 tb_clk = ~tb_clk;

  ann_layer_sequencer_if #(.NUM_INPUTS(NI), .NUM_NODES(NN), .NUM_LAYERS(NL)) bus ();

  ann_layer_sequencer #(.NUM_INPUTS(NI), .NUM_NODES(NN), .NUM_LAYERS(NL)) dut (
    .clk (tb_clk),
    .rst (rst),
    .bus (bus)
  );

  function automatic obs_t sample();
    obs_t o;
    o.busy         = bus.busy;
    o.request_coef = bus.request_coef;
    o.coef_select  = bus.coef_select;
    o.mac_clear    = bus.mac_clear;
    o.mac_en       = bus.mac_en;
    o.node_latch   = bus.node_latch;
    o.done         = bus.done_processing;
    o.addr         = bus.input_addr;
    o.node         = bus.node_sel;
    o.layer        = bus.layer_idx;
    return o;
  endfunction

  // Expected outputs at cycle t (0 = first mac_clear) of a layer: each node is
  // one clear cycle, NI accumulate cycles, one latch cycle.
  function automatic obs_t exp_layer(input int layer, input int t);
    obs_t e;
    int   p;
    int   n;
    p = t % NODE_CYC;
    n = t / NODE_CYC;
    e = '0;
    e.busy        = 1'b1;
    e.coef_select = (layer % 2) == 1;
    e.node        = 4'(n);
    e.layer       = 2'(layer);
    if (p == 0) begin
      e.mac_clear = 1'b1;
    end else if (p <= NI) begin
      e.mac_en = 1'b1;
      e.addr   = 6'(p - 1);
    end else begin
      e.node_latch = 1'b1;
    end
    return e;
  endfunction

  function automatic obs_t exp_req(input int layer);
    obs_t e;
    e = '0;
    e.busy         = 1'b1;
    e.request_coef = 1'b1;
    e.coef_select  = (layer % 2) == 1;
    e.node         = 4'(NN - 1);
    e.layer        = 2'(layer);
    return e;
  endfunction

  function automatic obs_t exp_done();
    obs_t e;
    e = '0;
    e.busy        = 1'b1;
    e.done        = 1'b1;
    e.coef_select = ((NL - 1) % 2) == 1;
    e.node        = 4'(NN - 1);
    e.layer       = 2'(NL - 1);
    return e;
  endfunction

  // input_addr only has defined meaning in clear/accumulate cycles.
  function automatic obs_t mask_for(input obs_t e, input bit skip_coef);
    obs_t m;
    m = '1;
    if (!(e.mac_clear || e.mac_en)) m.addr = '0;
    if (skip_coef) m.coef_select = 1'b0;
    return m;
  endfunction

  task automatic run_image(input int stop_layer, input int stop_t, input int spur_pct,
                           input bit pulse_latch15, input bit pulse_on_done, input int first_wait);
    obs_t e;
    obs_t o;
    obs_t m;
    int   w;
    int   hold;
    @(negedge tb_clk);
    bus.image_weights_loaded = 1'b1;
    hold = $urandom_range(0, 2);
    for (int l = 0; l < NL; l++) begin
      for (int t = 0; t < LAYER_CYC; t++) begin
        @(negedge tb_clk);
        e = exp_layer(l, t);
        m = mask_for(e, 1'b0);
        o = sample();
        checks++;
        if (((o ^ e) & m) !== '0) begin
          errors++;
          $display("FAIL layer_cycle layer=%0d t=%0d got=%h expected=%h", l, t, o, e);
        end
        if (l == stop_layer && t == stop_t) return;
        // Any loader activity while a layer is running must be ignored.
        if (hold > 0) begin
          bus.image_weights_loaded = 1'b1;
          hold--;
        end else if (pulse_latch15 && t == LAYER_CYC - 1) begin
          bus.image_weights_loaded = 1'b1;
        end else begin
          bus.image_weights_loaded = ($urandom_range(0, 99) < spur_pct);
        end
      end
      if (l < NL - 1) begin
        w = (l == 0) ? first_wait : $urandom_range(1, 5);
        for (int k = 0; k < w; k++) begin
          @(negedge tb_clk);
          e = exp_req(l);
          m = mask_for(e, 1'b0);
          o = sample();
          checks++;
          if (((o ^ e) & m) !== '0) begin
            errors++;
            $display("FAIL req_wait layer=%0d k=%0d got=%h expected=%h", l, k, o, e);
          end
          bus.image_weights_loaded = (k == w - 1);
        end
        hold = $urandom_range(0, 3);
      end else begin
        @(negedge tb_clk);
        e = exp_done();
        m = mask_for(e, 1'b0);
        o = sample();
        checks++;
        if (((o ^ e) & m) !== '0) begin
          errors++;
          $display("FAIL done_pulse got=%h expected=%h", o, e);
        end
        bus.image_weights_loaded = pulse_on_done;
        for (int k = 0; k < 4; k++) begin
          @(negedge tb_clk);
          e = '0;
          m = mask_for(e, 1'b1);
          o = sample();
          checks++;
          if (((o ^ e) & m) !== '0) begin
            errors++;
            $display("FAIL idle_after_done k=%0d got=%h expected=%h", k, o, e);
          end
          bus.image_weights_loaded = 1'b0;
        end
      end
    end
  endtask

  task automatic test_reset();
    obs_t o;
    rst = 1'b1;
    bus.image_weights_loaded = 1'b0;
    repeat (2) @(negedge tb_clk);
    o = sample();
    checks++;
    if (o !== '0) begin
      errors++;
      $display("FAIL reset_state got=%h expected=0", o);
    end
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge tb_clk);
      o = sample();
      checks++;
      if (o !== '0) begin
        errors++;
        $display("FAIL idle_after_reset k=%0d got=%h expected=0", k, o);
      end
    end
  endtask

  task automatic test_full_image_with_stray_pulses();
    run_image(-1, 0, 5, 1'b1, 1'b1, 3);
  endtask

  task automatic test_back_to_back_images();
    run_image(-1, 0, 20, 1'b0, 1'b0, $urandom_range(1, 6));
    run_image(-1, 0, 0, 1'b1, 1'b1, 1);
  endtask

  task automatic test_async_reset_mid_layer();
    obs_t o;
    run_image(2, 7 * NODE_CYC + 30, 3, 1'b0, 1'b0, 2);
    bus.image_weights_loaded = 1'b0;
    rst = 1'b1;
    #1;
    o = sample();
    checks++;
    if (o !== '0) begin
      errors++;
      $display("FAIL async_reset got=%h expected=0", o);
    end
    @(negedge tb_clk);
    rst = 1'b0;
    @(negedge tb_clk);
    o = sample();
    checks++;
    if (o !== '0) begin
      errors++;
      $display("FAIL idle_after_async_reset got=%h expected=0", o);
    end
  endtask

  task automatic test_restart_after_reset();
    run_image(-1, 0, 5, 1'b1, 1'b0, 3);
  endtask

  initial begin
    test_reset();
    test_full_image_with_stray_pulses();
    test_back_to_back_images();
    test_async_reset_mid_layer();
    test_restart_after_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
